mips32_prog_loader: RTL and testbench

MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

---
 rtl/mips32_pkg.sv | 8 +
 rtl/mips32_byte_packer.sv | 42 ++++
 rtl/mips32_prog_loader.sv | 136 +++++++++++++
 tb/tb_mips32_prog_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 program loader.
package mips32_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, FIN} state_t;
endpackage

// File: rtl/mips32_byte_packer.sv
// Byte-to-word assembler: shifts accepted bytes into a 32-bit word in the
// configured byte order and flags when the next byte completes the word.
module mips32_byte_packer
  import mips32_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word_next,
  output logic              last
);
  logic [WORD_W-1:0] word_reg;
  logic [BCNT_W-1:0] cnt_reg;

  generate
    if (BIG_ENDIAN != 0) begin : g_be
      assign word_next = {word_reg[WORD_W-9:0], din};
    end else begin : g_le
      assign word_next = {din, word_reg[WORD_W-1:8]};
    end
  endgenerate

  assign last = (cnt_reg == BCNT_W'(BYTES_PER_WORD - 1));

  // Counter wraps naturally back to 0 after the fourth byte.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      cnt_reg  <= '0;
    end else if (clr) begin
      word_reg <= '0;
      cnt_reg  <= '0;
    end else if (shift) begin
      word_reg <= word_next;
      cnt_reg  <= cnt_reg + BCNT_W'(1);
    end
  end
endmodule

// File: rtl/mips32_prog_loader.sv
// Streams bytes into 32-bit words and writes them to program memory while
// holding the CPU halted. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              done_reg;
  logic              hs;
  logic              last;
  logic [WORD_W-1:0] word_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg;
  logic              error_reg;
`endif

  assign hs = s_valid & s_ready;

  mips32_byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .clr       (state_reg == IDLE),
    .shift     ((state_reg == RECV) && hs),
    .din       (s_data),
    .word_next (word_next),
    .last      (last)
  );

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = (word_count == '0) ? FIN : RECV;
      RECV: begin
        s_ready = 1'b1;
        if (hs && last) state_next = WRITE;
      end
      WRITE: begin
        if (count_reg != (ADDR_W+1)'(1)) state_next = RECV;
`ifdef LOADER_CHECKSUM_EN
        else state_next = CHECK;
`else
        else state_next = FIN;
`endif
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        s_ready = 1'b1;
        if (s_valid) state_next = FIN;
`else
        state_next = FIN;
`endif
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg  <= '0;
      error_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          addr_reg  <= base_addr;
          count_reg <= word_count;
          done_reg  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_reg  <= '0;
          error_reg <= 1'b0;
`endif
        end
        RECV: if (hs) begin
`ifdef LOADER_CHECKSUM_EN
          csum_reg <= csum_reg ^ s_data;
`endif
          // Capture the finished word so it is presented during WRITE.
          if (last) begin
            mem_addr  <= addr_reg;
            mem_wdata <= word_next;
          end
        end
        WRITE: begin
          addr_reg  <= addr_reg + ADDR_W'(1);
          count_reg <= count_reg - (ADDR_W+1)'(1);
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (s_valid) error_reg <= (s_data != csum_reg);
`endif
        default: ;
      endcase
      // Later assignment wins, so a zero-length start still ends with done set.
      if (state_next == FIN) done_reg <= 1'b1;
    end
  end

  assign mem_we   = (state_reg == WRITE);
  assign busy     = (state_reg != IDLE);
  assign cpu_halt = busy;
  assign done     = done_reg;
`ifdef LOADER_CHECKSUM_EN
  assign error    = error_reg;
`else
  assign error    = 1'b0;
`endif
endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: one big-endian and one little-endian instance
// share all inputs; a write scoreboard per instance checks every mem_we.
module tb_mips32_prog_loader;
  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;

  logic        s_ready_be, mem_we_be, cpu_halt_be, busy_be, done_be, error_be;
  logic [9:0]  mem_addr_be;
  logic [31:0] mem_wdata_be;
  logic        s_ready_le, mem_we_le, cpu_halt_le, busy_le, done_le, error_le;
  logic [9:0]  mem_addr_le;
  logic [31:0] mem_wdata_le;

  int total = 0;
  int bad = 0;
  int viol = 0;
  bit watch = 1'b0;
  logic [41:0] exp_be[$];
  logic [41:0] exp_le[$];
  logic [31:0] prog[16];

  always #5 clk1 = ~clk1;

  mips32_prog_loader #(.ADDR_W(10), .BIG_ENDIAN(1)) dut_be (
    .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_be), .mem_we(mem_we_be), .mem_addr(mem_addr_be),
    .mem_wdata(mem_wdata_be), .cpu_halt(cpu_halt_be), .busy(busy_be),
    .done(done_be), .error(error_be)
  );

  mips32_prog_loader #(.ADDR_W(10), .BIG_ENDIAN(0)) dut_le (
    .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_le), .mem_we(mem_we_le), .mem_addr(mem_addr_le),
    .mem_wdata(mem_wdata_le), .cpu_halt(cpu_halt_le), .busy(busy_le),
    .done(done_le), .error(error_le)
  );

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Scoreboard: each write is popped against the expectation queued at drive time.
  always @(negedge clk1) begin
    if (mem_we_be) begin
      total++;
      if (exp_be.size() == 0) begin
        bad++;
        $display("FAIL wr_be unexpected write addr=%0d data=%h", mem_addr_be, mem_wdata_be);
      end else begin
        logic [41:0] e;
        e = exp_be.pop_front();
        if ({mem_addr_be, mem_wdata_be} !== e) begin
          bad++;
          $display("FAIL wr_be got addr=%0d data=%h want addr=%0d data=%h",
                   mem_addr_be, mem_wdata_be, e[41:32], e[31:0]);
        end else
          $display("write be addr=%0d data=%h ok", mem_addr_be, mem_wdata_be);
      end
    end
    if (mem_we_le) begin
      total++;
      if (exp_le.size() == 0) begin
        bad++;
        $display("FAIL wr_le unexpected write addr=%0d data=%h", mem_addr_le, mem_wdata_le);
      end else begin
        logic [41:0] e;
        e = exp_le.pop_front();
        if ({mem_addr_le, mem_wdata_le} !== e) begin
          bad++;
          $display("FAIL wr_le got addr=%0d data=%h want addr=%0d data=%h",
                   mem_addr_le, mem_wdata_le, e[41:32], e[31:0]);
        end else
          $display("write le addr=%0d data=%h ok", mem_addr_le, mem_wdata_le);
      end
    end
    if (watch && (!busy_be || !cpu_halt_be)) viol++;
  end

  task automatic do_start(input logic [9:0] base, input logic [10:0] cnt);
    @(negedge clk1);
    start = 1'b1;
    base_addr = base;
    word_count = cnt;
    @(posedge clk1);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) @(posedge clk1);
    #1;
    s_valid = 1'b1;
    s_data = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk1);
      if (s_ready_be) begin
        @(posedge clk1);
        got = 1'b1;
        break;
      end
    end
    #1 s_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL handshake byte=%h never accepted", b);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk1);
      if (!busy_be) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL idle_timeout busy=%b want 0", busy_be);
    end
  endtask

  // Loads prog[0..n-1] at base; checks write latency, done and error afterwards.
  task automatic load_words(input logic [9:0] base, input int n, input int gap, input bit csum_good);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    do_start(base, 11'(n));
    watch = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = prog[k];
      exp_be.push_back({10'(base + 10'(k)), w});
      exp_le.push_back({10'(base + 10'(k)), bswap(w)});
      for (int j = 3; j >= 0; j--) begin
        send_byte(w[j*8 +: 8], gap);
        x = x ^ w[j*8 +: 8];
      end
      @(negedge clk1);
      total++;
      if (mem_we_be !== 1'b1) begin
        bad++;
        $display("FAIL latency word=%0d mem_we=%b want 1", k, mem_we_be);
      end
    end
    watch = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_good ? x : ~x, 0);
`endif
    wait_idle();
    total++;
    if ({done_be, done_le, cpu_halt_be} !== 3'b110) begin
      bad++;
      $display("FAIL done_after_load done=%b/%b halt=%b want 1/1 0", done_be, done_le, cpu_halt_be);
    end
    total++;
`ifdef LOADER_CHECKSUM_EN
    if (error_be !== !csum_good) begin
      bad++;
      $display("FAIL error_flag got=%b want=%b", error_be, !csum_good);
    end
`else
    if (error_be !== (csum_good ? 1'b0 : 1'b0)) begin
      bad++;
      $display("FAIL error_flag got=%b want=0", error_be);
    end
`endif
    $display("load base=%0d words=%0d gap=%0d done", base, n, gap);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk1);
    total++;
    if ({s_ready_be, mem_we_be, mem_addr_be, mem_wdata_be, cpu_halt_be, busy_be, done_be, error_be} !== '0) begin
      bad++;
      $display("FAIL reset_outputs ready=%b we=%b addr=%0d data=%h halt=%b busy=%b done=%b err=%b want all 0",
               s_ready_be, mem_we_be, mem_addr_be, mem_wdata_be, cpu_halt_be, busy_be, done_be, error_be);
    end
    @(negedge clk1) rst_n = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_endian();
    prog[0] = 32'h28010078;
    load_words(10'd0, 1, 0, 1'b1);
    prog[0] = 32'h78000128;
    load_words(10'd4, 1, 0, 1'b1);
  endtask

  task automatic test_toggle();
    prog[0] = 32'h20080005; prog[1] = 32'h2009000a;
    prog[2] = 32'h01095020; prog[3] = 32'hac0a0000;
    prog[4] = 32'h8c0b0000; prog[5] = 32'h216bffff;
    prog[6] = 32'h1560fffe; prog[7] = 32'h08000000;
    viol = 0;
    load_words(10'd0, 8, 1, 1'b1);
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL busy_halt_held low_cycles=%0d want 0", viol);
    end
  endtask

  task automatic test_wrap_and_busy_start();
    logic [31:0] w;
    prog[0] = 32'hdeadbeef; prog[1] = 32'h00c0ffee;
    do_start(10'd1023, 11'd2);
    for (int k = 0; k < 2; k++) begin
      w = prog[k];
      exp_be.push_back({(k == 0) ? 10'd1023 : 10'd0, w});
      exp_le.push_back({(k == 0) ? 10'd1023 : 10'd0, bswap(w)});
      for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8], 0);
      // A start pulse mid-load must not retarget the remaining words.
      if (k == 0) do_start(10'd77, 11'd5);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hde ^ 8'had ^ 8'hbe ^ 8'hef ^ 8'h00 ^ 8'hc0 ^ 8'hff ^ 8'hee, 0);
`endif
    wait_idle();
    total++;
    if (done_be !== 1'b1) begin
      bad++;
      $display("FAIL wrap_done done=%b want 1", done_be);
    end
  endtask

  task automatic test_zero_count();
    do_start(10'd9, 11'd0);
    @(negedge clk1);
    total++;
    if ({busy_be, done_be, s_ready_be, mem_we_be} !== 4'b1100) begin
      bad++;
      $display("FAIL zero_fin busy=%b done=%b ready=%b we=%b want 1 1 0 0", busy_be, done_be, s_ready_be, mem_we_be);
    end
    @(negedge clk1);
    total++;
    if ({busy_be, done_be, cpu_halt_be} !== 3'b010) begin
      bad++;
      $display("FAIL zero_idle busy=%b done=%b halt=%b want 0 1 0", busy_be, done_be, cpu_halt_be);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w;
    prog[0] = 32'h11111111; prog[1] = 32'h22222222; prog[2] = 32'h33445566;
    do_start(10'd0, 11'd5);
    for (int k = 0; k < 2; k++) begin
      w = prog[k];
      exp_be.push_back({10'(k), w});
      exp_le.push_back({10'(k), bswap(w)});
      for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8], 0);
    end
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready_be, mem_we_be, mem_addr_be, mem_wdata_be, cpu_halt_be, busy_be, done_be, error_be} !== '0) begin
      bad++;
      $display("FAIL midload_reset ready=%b we=%b addr=%0d data=%h halt=%b busy=%b done=%b want all 0",
               s_ready_be, mem_we_be, mem_addr_be, mem_wdata_be, cpu_halt_be, busy_be, done_be);
    end
    s_valid = 1'b1;
    s_data = 8'h55;
    repeat (3) @(negedge clk1);
    s_valid = 1'b0;
    rst_n = 1'b1;
    prog[0] = 32'h12345678;
    load_words(10'd3, 1, 0, 1'b1);
  endtask

  task automatic test_trailer();
`ifdef LOADER_CHECKSUM_EN
    prog[0] = 32'h28010078;
    load_words(10'd0, 1, 0, 1'b1);
    load_words(10'd0, 1, 0, 1'b0);
`else
    int seen;
    seen = 0;
    s_valid = 1'b1;
    s_data = 8'h51;
    repeat (4) begin
      @(negedge clk1);
      if (s_ready_be || busy_be) seen++;
    end
    s_valid = 1'b0;
    total++;
    if (seen !== 0 || error_be !== 1'b0) begin
      bad++;
      $display("FAIL trailer_ignored ready_cycles=%0d err=%b want 0 0", seen, error_be);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_endian();
    test_toggle();
    test_wrap_and_busy_start();
    test_zero_count();
    test_reset_midload();
    test_trailer();
    repeat (3) @(negedge clk1);
    total++;
    if (exp_be.size() != 0 || exp_le.size() != 0) begin
      bad++;
      $display("FAIL missing_writes left=%0d/%0d want 0/0", exp_be.size(), exp_le.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
